// File: rtl/mario_obj_dma.sv
// Object DMA: copies LEN sprite-attribute bytes from CPU work RAM into object RAM,
// taking the CPU bus through a BUSRQ/BUSAK handshake. The FSM steps only on I_CEN ticks.
module mario_obj_dma #(
    parameter int          LEN      = 384,
    parameter logic [9:0]  DST_BASE = 10'd0
) (
    input  logic        I_CLK_48M,
    input  logic        I_RESETn,
    input  logic        I_CEN,
    input  logic        I_START,
    input  logic [15:0] I_SRC_BASE,
    input  logic        I_BUSAKn,
    input  logic [7:0]  I_SRC_D,
    output logic        O_BUSRQn,
    output logic [15:0] O_SRC_A,
    output logic [9:0]  O_DMAD_A,
    output logic [7:0]  O_DMAD_D,
    output logic        O_DMAD_CE,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, RELEASE} state_t;

    localparam logic [9:0] LAST_INDEX = 10'(LEN - 1);

    state_t      state;
    logic        pending;
    logic [9:0]  index;
    logic [15:0] base;

    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state     <= IDLE;
            pending   <= 1'b0;
            index     <= 10'd0;
            base      <= 16'd0;
            O_BUSRQn  <= 1'b1;
            O_SRC_A   <= 16'd0;
            O_DMAD_A  <= 10'd0;
            O_DMAD_D  <= 8'd0;
            O_DMAD_CE <= 1'b0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
        end else begin
            O_DMAD_CE <= 1'b0;
            O_DONE    <= 1'b0;

            // Requests are latched on every clock, but only while idle; clearing below wins.
            if (state == IDLE && I_START)
                pending <= 1'b1;

            if (I_CEN) begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            pending  <= 1'b0;
                            base     <= I_SRC_BASE;
                            index    <= 10'd0;
                            O_BUSRQn <= 1'b0;
                            O_BUSY   <= 1'b1;
                            state    <= REQ;
                        end
                    end
                    REQ: begin
                        if (!I_BUSAKn) begin
                            O_SRC_A <= base + 16'(index);
                            state   <= READ;
                        end
                    end
                    READ: begin
                        if (!I_BUSAKn) begin
                            O_DMAD_D  <= I_SRC_D;
                            O_DMAD_A  <= DST_BASE + index;
                            O_DMAD_CE <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                    WRITE: begin
                        // A lost acknowledge freezes READ/WRITE in place until the bus returns.
                        if (!I_BUSAKn) begin
                            if (index == LAST_INDEX) begin
                                O_BUSRQn <= 1'b1;
                                state    <= RELEASE;
                            end else begin
                                index   <= index + 10'd1;
                                O_SRC_A <= base + 16'(index) + 16'd1;
                                state   <= READ;
                            end
                        end
                    end
                    RELEASE: begin
                        if (I_BUSAKn) begin
                            O_BUSY <= 1'b0;
                            O_DONE <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mario_obj_dma.sv
// Directed bench for mario_obj_dma: a short-transfer instance (LEN=4) and a full-length
// instance (LEN=384, DST_BASE=1022) with bus-acknowledge models and strobe loggers.
module tb_mario_obj_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen = 1'b0;
    logic [1:0] cen_cnt = 2'd0;

    always #5 clk = ~clk;

    // One cen tick every fourth clock so gating is exercised.
    always @(posedge clk) begin
        cen_cnt <= cen_cnt + 2'd1;
        cen     <= (cen_cnt == 2'd3);
    end

    logic        start, busak, busak_m, steal;
    logic [7:0]  flip, src_d;
    logic [15:0] src_base;
    logic        busrq, ce, busy, done;
    logic [15:0] src_a;
    logic [9:0]  dmad_a;
    logic [7:0]  dmad_d;

    assign busak = busak_m | steal;
    assign src_d = src_a[7:0] ^ flip;

    always @(posedge clk or negedge rst_n)
        if (!rst_n)   busak_m <= 1'b1;
        else if (cen) busak_m <= busrq;

    mario_obj_dma #(.LEN(4), .DST_BASE(10'd0)) dut (
        .I_CLK_48M(clk), .I_RESETn(rst_n), .I_CEN(cen), .I_START(start),
        .I_SRC_BASE(src_base), .I_BUSAKn(busak), .I_SRC_D(src_d),
        .O_BUSRQn(busrq), .O_SRC_A(src_a), .O_DMAD_A(dmad_a), .O_DMAD_D(dmad_d),
        .O_DMAD_CE(ce), .O_BUSY(busy), .O_DONE(done)
    );

    logic        start2, busak2, busrq2, ce2, busy2, done2;
    logic [15:0] src_base2, src_a2;
    logic [9:0]  dmad_a2;
    logic [7:0]  dmad_d2;

    always @(posedge clk or negedge rst_n)
        if (!rst_n)   busak2 <= 1'b1;
        else if (cen) busak2 <= busrq2;

    mario_obj_dma #(.LEN(384), .DST_BASE(10'd1022)) dut2 (
        .I_CLK_48M(clk), .I_RESETn(rst_n), .I_CEN(cen), .I_START(start2),
        .I_SRC_BASE(src_base2), .I_BUSAKn(busak2), .I_SRC_D(src_a2[7:0]),
        .O_BUSRQn(busrq2), .O_SRC_A(src_a2), .O_DMAD_A(dmad_a2), .O_DMAD_D(dmad_d2),
        .O_DMAD_CE(ce2), .O_BUSY(busy2), .O_DONE(done2)
    );

    logic [9:0]  log_a [64];
    logic [7:0]  log_d [64];
    int          ce_cnt = 0, done_cnt = 0, steal_ce = 0;

    always @(negedge clk) begin
        if (ce && ce_cnt < 64) begin
            log_a[ce_cnt] <= dmad_a;
            log_d[ce_cnt] <= dmad_d;
        end
        if (ce)          ce_cnt   <= ce_cnt + 1;
        if (ce && steal) steal_ce <= steal_ce + 1;
        if (done)        done_cnt <= done_cnt + 1;
    end

    logic [9:0]  log2_a [512];
    logic [7:0]  log2_d [512];
    logic [15:0] log2_s [512];
    int          log2_t [512];
    int          ce2_cnt = 0, done2_cnt = 0, tick_cnt = 0, ack_tick = -1;
    logic        busak2_q = 1'b1;

    // Each strobe is tagged with the cen tick that launched it.
    always @(negedge clk) begin
        if (ce2 && ce2_cnt < 512) begin
            log2_a[ce2_cnt] <= dmad_a2;
            log2_d[ce2_cnt] <= dmad_d2;
            log2_s[ce2_cnt] <= src_a2;
            log2_t[ce2_cnt] <= tick_cnt;
        end
        if (ce2)  ce2_cnt   <= ce2_cnt + 1;
        if (done2) done2_cnt <= done2_cnt + 1;
        if (cen)  tick_cnt  <= tick_cnt + 1;
        busak2_q <= busak2;
        if (!busak2 && busak2_q && ack_tick < 0) ack_tick <= tick_cnt;
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit to_dut2);
        @(negedge clk);
        if (to_dut2) start2 = 1'b1;
        else         start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitBusy(input bit which, input bit level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? busy2 : busy) == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitStrobes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ce_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkXfer(input string tag, input int snap, input int dsnap);
        checkOutput({tag, "_strobes"}, 32'(ce_cnt - snap), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, "_dma_a"}, 32'(log_a[snap + i]), 32'(i));
            checkOutput({tag, "_dma_d"}, 32'(log_d[snap + i]), 32'(i));
        end
        checkOutput({tag, "_done"}, 32'(done_cnt - dsnap), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  snap, dsnap, n, a_err, d_err, gap_err;
        bit  ok;
        logic [15:0] exp_s;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; steal = 1'b0; flip = 8'h00;
        src_base = 16'h6900; src_base2 = 16'hFFFE;
        repeat (3) @(negedge clk);

        checkOutput("rst_busrq",  32'(busrq),  32'd1);
        checkOutput("rst_src_a",  32'(src_a),  32'd0);
        checkOutput("rst_dma_a",  32'(dmad_a), 32'd0);
        checkOutput("rst_dma_d",  32'(dmad_d), 32'd0);
        checkOutput("rst_ce",     32'(ce),     32'd0);
        checkOutput("rst_busy",   32'(busy),   32'd0);
        checkOutput("rst_done",   32'(done),   32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        $display("[TB] basic transfer");
        snap = ce_cnt; dsnap = done_cnt;
        applyStimulus(1'b0);
        waitBusy(1'b0, 1'b1, 40, ok);
        checkOutput("basic_busy_rise", 32'(ok), 32'd1);
        checkOutput("basic_busrq_low", 32'(busrq), 32'd0);
        waitBusy(1'b0, 1'b0, 400, ok);
        checkOutput("basic_finish", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        checkXfer("basic", snap, dsnap);
        checkOutput("hold_dma_a", 32'(dmad_a), 32'd3);
        checkOutput("hold_dma_d", 32'(dmad_d), 32'd3);
        checkOutput("basic_busrq_rel", 32'(busrq), 32'd1);

        $display("[TB] start while busy");
        snap = ce_cnt; dsnap = done_cnt;
        applyStimulus(1'b0);
        waitStrobes(snap + 1, 400, ok);
        checkOutput("busy_first_strobe", 32'(ok), 32'd1);
        applyStimulus(1'b0);
        waitBusy(1'b0, 1'b0, 400, ok);
        checkOutput("busy_finish", 32'(ok), 32'd1);
        repeat (60) @(negedge clk);
        checkXfer("busy", snap, dsnap);

        $display("[TB] bus steal");
        snap = ce_cnt; dsnap = done_cnt;
        applyStimulus(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (src_a == 16'h6901) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("steal_reach_byte", 32'(ok), 32'd1);
        steal = 1'b1;
        flip  = 8'h5A;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (cen) n++;
        end
        @(negedge clk);
        checkOutput("steal_strobes_held", 32'(ce_cnt - snap), 32'd1);
        steal = 1'b0;
        flip  = 8'h00;
        waitBusy(1'b0, 1'b0, 400, ok);
        checkOutput("steal_finish", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        checkXfer("steal", snap, dsnap);
        checkOutput("steal_ce_in_stall", 32'(steal_ce), 32'd0);

        $display("[TB] async reset mid-transfer");
        snap = ce_cnt; dsnap = done_cnt;
        applyStimulus(1'b0);
        waitStrobes(snap + 2, 400, ok);
        checkOutput("rstmid_progress", 32'(ok), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busrq", 32'(busrq), 32'd1);
        checkOutput("rstmid_busy",  32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("rstmid_no_done", 32'(done_cnt - dsnap), 32'd0);
        snap = ce_cnt; dsnap = done_cnt;
        applyStimulus(1'b0);
        waitBusy(1'b0, 1'b1, 40, ok);
        checkOutput("rstmid_restart", 32'(ok), 32'd1);
        waitBusy(1'b0, 1'b0, 400, ok);
        checkOutput("rstmid_finish", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        checkXfer("rstmid", snap, dsnap);

        $display("[TB] full length with address wrap");
        applyStimulus(1'b1);
        waitBusy(1'b1, 1'b1, 40, ok);
        checkOutput("full_busy_rise", 32'(ok), 32'd1);
        waitBusy(1'b1, 1'b0, 6000, ok);
        checkOutput("full_finish", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("full_strobes", 32'(ce2_cnt), 32'd384);
        checkOutput("full_done", 32'(done2_cnt), 32'd1);
        checkOutput("wrap_src0", 32'(log2_s[0]), 32'hFFFE);
        checkOutput("wrap_src1", 32'(log2_s[1]), 32'hFFFF);
        checkOutput("wrap_src2", 32'(log2_s[2]), 32'h0000);
        checkOutput("wrap_src3", 32'(log2_s[3]), 32'h0001);
        checkOutput("wrap_dst0", 32'(log2_a[0]), 32'd1022);
        checkOutput("wrap_dst1", 32'(log2_a[1]), 32'd1023);
        checkOutput("wrap_dst2", 32'(log2_a[2]), 32'd0);
        checkOutput("wrap_dst3", 32'(log2_a[3]), 32'd1);
        checkOutput("first_ce_latency", 32'(log2_t[0] - ack_tick), 32'd2);
        a_err = 0; d_err = 0; gap_err = 0;
        for (int i = 0; i < 384; i++) begin
            exp_s = 16'hFFFE + 16'(i);
            if (log2_a[i] != 10'((1022 + i) % 1024)) a_err++;
            if (log2_d[i] != exp_s[7:0])             d_err++;
            if (i > 0 && (log2_t[i] - log2_t[i-1]) != 2) gap_err++;
        end
        checkOutput("full_addr_errs", 32'(a_err), 32'd0);
        checkOutput("full_data_errs", 32'(d_err), 32'd0);
        checkOutput("full_gap_errs",  32'(gap_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
